// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the configurable serial pattern detector.
package seq_det_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Width needed to hold a pattern length of 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit-matching datapath: history shift register, fill counter and masked compare.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               in_bit,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               hit
);

    // The oldest history bit is never compared after the shift, so it is not stored.
    logic [MAX_LEN-2:0] hist;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_n;
    logic [LEN_W:0]     fill_inc;

    always_comb begin
        hist_n   = {hist, in_bit};
        fill_inc = {1'b0, fill} + (LEN_W + 1)'(1);
        fill_n   = (fill_inc > {1'b0, len}) ? len : fill_inc[LEN_W-1:0];
        mask     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        hit = shift_en && (fill_n == len) && (((hist_n ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= hist_n[MAX_LEN-2:0];
            fill <= (hit && !overlap) ? '0 : fill_n;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-time-programmable serial pattern-detection controller: config regs, FSM,
// saturating match counter and status outputs around seq_match_core.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [len_width(MAX_LEN)-1:0]  cfg_len,
    input  logic                           cfg_overlap,
    input  logic [CNT_W-1:0]               cfg_thresh,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           in_valid,
    input  logic                           in_bit,
    output logic                           busy,
    output logic                           match,
    output logic [CNT_W-1:0]               match_cnt,
    output logic                           done,
    output logic                           cfg_err
);

    localparam int LEN_W = len_width(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    state_t             state, state_n;
    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic               overlap_r;
    logic [CNT_W-1:0]   thresh_r;

    logic               cfg_open, cfg_ok, start_ok, start_bad;
    logic               shift_en, core_clear, hit, reach;
    logic [CNT_W-1:0]   cnt_inc;

    // Config and start are only honoured while the datapath is quiescent; stop blocks start.
    always_comb begin
        cfg_open   = (state == IDLE) || (state == DONE);
        cfg_ok     = (cfg_len != '0) && (cfg_len <= MAX_LEN_V);
        start_ok   = cfg_open && start && !stop && (len_r != '0);
        start_bad  = cfg_open && start && !stop && (len_r == '0);
        shift_en   = (state == RUN) && in_valid && !stop;
        core_clear = (state == ARM);
        cnt_inc    = (match_cnt == {CNT_W{1'b1}}) ? match_cnt : match_cnt + CNT_W'(1);
        reach      = hit && (thresh_r != '0) && (cnt_inc == thresh_r);
    end

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clear    (core_clear),
        .shift_en (shift_en),
        .in_bit   (in_bit),
        .pattern  (pattern_r),
        .len      (len_r),
        .overlap  (overlap_r),
        .hit      (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (start_ok) state_n = ARM;
            ARM:        state_n = stop ? IDLE : RUN;
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (reach) begin
                    state_n = DONE;
                end
            end
            default:    state_n = IDLE;
        endcase
    end

    // A rejected start or a bad write sets the error even if a good write lands the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_r <= '0;
            len_r     <= '0;
            overlap_r <= 1'b0;
            thresh_r  <= '0;
            cfg_err   <= 1'b0;
            match     <= 1'b0;
            match_cnt <= '0;
            done      <= 1'b0;
        end else begin
            if (cfg_open && cfg_we && cfg_ok) begin
                pattern_r <= cfg_pattern;
                len_r     <= cfg_len;
                overlap_r <= cfg_overlap;
                thresh_r  <= cfg_thresh;
            end
            if (start_bad || (cfg_open && cfg_we && !cfg_ok)) begin
                cfg_err <= 1'b1;
            end else if (cfg_open && cfg_we) begin
                cfg_err <= 1'b0;
            end
            match <= hit;
            if (start_ok) begin
                match_cnt <= '0;
                done      <= 1'b0;
            end else if (hit) begin
                match_cnt <= cnt_inc;
                if (reach) begin
                    done <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == ARM) || (state == RUN);

endmodule
